// File: rtl/vga_plot_buffer.sv
// vga_plot_buffer
//   Buffers rasterizer pixels in a small FIFO and forwards them to the VGA
//   adapter, one plot strobe per pixel. Off-screen pixels are dropped and
//   counted. On request it drains the FIFO and sweeps the whole screen with
//   the background colour.
//
// Ports
//   clk, reset           system clock; synchronous active-low reset
//   in_valid/x/y/colour  rasterizer pixel stream
//   in_ready             pixel can be accepted this cycle
//   clear_req            request a full-screen clear (sampled in PASS only)
//   clear_busy           draining for a clear or sweeping
//   vga_x/y/colour/plot  registered pixel and write strobe to the adapter
//   clip_count           saturating count of discarded off-screen pixels
module vga_plot_buffer #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  output logic       in_ready,
  input  logic       clear_req,
  output logic       clear_busy,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [7:0] clip_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [8:0]  W_LIM    = 9'(SCREEN_W);
  localparam logic [7:0]  H_LIM    = 8'(SCREEN_H);
  localparam logic [7:0]  X_LAST   = 8'(SCREEN_W - 1);
  localparam logic [6:0]  Y_LAST   = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_PASS,
    S_DRAIN,
    S_CLEAR
  } state_t;

  state_t state, state_next;

  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    cx;
  logic [6:0]    cy;

  logic full, empty, accept, on_screen, push, pop, sweep_last;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign in_ready   = (state == S_PASS) && !full;
  assign clear_busy = (state != S_PASS);
  assign accept     = in_valid && in_ready;
  assign on_screen  = ({1'b0, in_x} < W_LIM) && ({1'b0, in_y} < H_LIM);
  assign push       = accept && on_screen;
  assign pop        = !empty && ((state == S_PASS) || (state == S_DRAIN));
  assign sweep_last = (cx == X_LAST) && (cy == Y_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_PASS;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_PASS:  if (clear_req)  state_next = S_DRAIN;
      S_DRAIN: if (empty)      state_next = S_CLEAR;
      S_CLEAR: if (sweep_last) state_next = S_PASS;
      default:                 state_next = S_PASS;
    endcase
  end

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_x, in_y, in_colour};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clip_count <= '0;
    end else if (accept && !on_screen && (clip_count != '1)) begin
      clip_count <= clip_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cx <= '0;
      cy <= '0;
    end else if (state == S_CLEAR) begin
      if (cx == X_LAST) begin
        cx <= '0;
        cy <= (cy == Y_LAST) ? '0 : cy + 7'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else if (state == S_CLEAR) begin
      vga_x      <= cx;
      vga_y      <= cy;
      vga_colour <= BG_COLOUR;
      vga_plot   <= 1'b1;
    end else if (pop) begin
      {vga_x, vga_y, vga_colour} <= mem[rd_ptr];
      vga_plot <= 1'b1;
    end else begin
      vga_plot <= 1'b0;
    end
  end

endmodule

// File: doc/vga_plot_buffer.md
Name: vga_plot_buffer

Overview:
- Sits between the object rasterizer (pixel stream: x, y, colour, valid) and the VGA adapter (x, y, colour, plot).
- Buffers rasterizer pixels in a small FIFO and discards off-screen pixels, counting them.
- Emits one plot strobe per pixel.
- Also runs a full-screen clear sweep on request, which the game uses to wipe the frame before a redraw.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- BG_COLOUR, 3'b000, colour written by the clear sweep.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  rasterizer pixel valid.
- in_x  input  8  pixel x.
- in_y  input  7  pixel y.
- in_colour  input  3  pixel colour.
- in_ready  output  1  buffer can accept a pixel this cycle.
- clear_req  input  1  request full-screen clear (level, sampled in PASS only).
- clear_busy  output  1  high while draining for a clear or sweeping.
- vga_x  output  8  registered x to the VGA adapter.
- vga_y  output  7  registered y to the VGA adapter.
- vga_colour  output  3  registered colour to the VGA adapter.
- vga_plot  output  1  one-cycle write strobe to the VGA adapter.
- clip_count  output  8  saturating count of discarded off-screen pixels.

Behaviour:
- Reset (reset==0 at an edge):
  - FIFO emptied, state=PASS, sweep counters=0.
  - vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, clip_count=0.
  - Reset mid-clear or mid-drain aborts immediately; no further plots until new input.
- in_ready is combinational: (state==PASS) && !full. It is 1 in the first cycle after reset.
  - Fullness is evaluated before the same-edge pop; there is no write-through when full.
- Accept: an edge with in_valid && in_ready.
  - If in_x >= SCREEN_W or in_y >= SCREEN_H: pixel is not stored; clip_count += 1, saturating at 255.
  - Otherwise: pixel is written at the write pointer.
- Pop: at every edge where the FIFO is non-empty and state is PASS or DRAIN, the head entry is registered onto vga_x/y/colour and vga_plot=1 for the following cycle.
  - Otherwise vga_plot=0 and vga_x/y/colour hold their last value.
  - The VGA adapter has no backpressure; one pop per cycle maximum.
- Latency: a pixel accepted at edge k appears with vga_plot=1 after edge k+1 (empty FIFO). In-order delivery.
- Simultaneous push and pop on the same edge is legal; occupancy is unchanged.
- Pointers wrap modulo DEPTH. The occupancy counter distinguishes full from empty.
- States:
  - PASS: normal operation. clear_req==1 -> DRAIN.
  - DRAIN: in_ready=0, clear_busy=1. Continue popping. Go to CLEAR at the edge where the FIFO is observed empty.
  - CLEAR: in_ready=0, clear_busy=1. Each cycle outputs vga_x=cx, vga_y=cy, vga_colour=BG_COLOUR, vga_plot=1.
    - cx increments 0..SCREEN_W-1, then wraps to 0 with cy += 1.
    - After the plot of (SCREEN_W-1, SCREEN_H-1): go to PASS and reset the counters.
    - Exactly SCREEN_W*SCREEN_H plots, raster order.
- clear_req is ignored in DRAIN/CLEAR. If still high on return to PASS, a new clear begins on the next edge.
- clear_busy is combinational from state. It goes low the first cycle back in PASS.
- clip_count is never cleared except by reset.

Test Plan:
- Reset then single pixel (10,20,3'b101) accepted at edge k -> vga_plot=1 with (10,20,5) after edge k+1 only; vga_plot=0 the cycles before and after.
- Hold vga stream busy with in_valid=1 for 20 pixels (0..19,5,c) -> all 20 plotted in order, one per cycle, in_ready never drops (pop rate equals push rate).
- Pixels (160,0), (0,120), (255,127) plus 300 further off-screen pixels -> no plots, clip_count ends at 255 (saturated), in_ready stays 1.
- Load FIFO with 4 pixels, pulse clear_req one cycle -> 4 pixels plotted first, then 19200 plots of BG_COLOUR from (0,0) to (159,119), clear_busy high throughout, in_ready=0 until PASS resumes.
- clear_req held high -> two back-to-back sweeps with exactly one PASS cycle between them (clear_busy low one cycle).
- Assert reset at sweep pixel (37,50) -> after reset vga_plot=0, state PASS, in_ready=1, clip_count=0; next accepted pixel plots normally.
